// File: rtl/acfa_log_ctrl.sv
// CFA metadata/log peripheral: challenge words, ER bounds, control/status and a
// hardware-appended control-flow log with an internally owned write pointer.
module acfa_log_ctrl #(
  parameter logic [14:0] BASE_ADDR  = 15'h0180,
  parameter int unsigned CHAL_WORDS = 16,
  parameter int unsigned LOG_AW     = 6
) (
  input  logic            mclk,
  input  logic            puc_rst_n,
  input  logic [13:0]     per_addr,
  input  logic [15:0]     per_din,
  input  logic            per_en,
  input  logic [1:0]      per_we,
  input  logic [15:0]     cflow_src,
  input  logic [15:0]     cflow_dest,
  input  logic            cflow_hw_wen,
  output logic [15:0]     per_dout,
  output logic [15:0]     ER_min,
  output logic [15:0]     ER_max,
  output logic [LOG_AW:0] log_ptr,
  output logic            log_full,
  output logic            irq_log
);

  localparam int unsigned LOG_DEPTH = 1 << LOG_AW;
  localparam int unsigned PW        = LOG_AW + 1;
  localparam int unsigned CAW       = (CHAL_WORDS > 1) ? $clog2(CHAL_WORDS) : 1;
  localparam int unsigned BASE_W    = 32'(BASE_ADDR >> 1);
  localparam int unsigned META_W    = BASE_W + CHAL_WORDS;
  localparam int unsigned LOG_W     = META_W + 8;
  localparam int unsigned END_W     = LOG_W + 2 * LOG_DEPTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(LOG_DEPTH);

  logic [31:0]       addr_w;
  logic              sel_chal, sel_meta, sel_log;
  logic [CAW-1:0]    chal_idx;
  logic [2:0]        meta_idx;
  logic [PW-1:0]     log_off;
  logic              wr_en, rd_en;

  logic [15:0]       ermin_q, ermin_d, ermax_q, ermax_d;
  logic [PW-1:0]     ptr_q, ptr_d, base_ptr;
  logic              mode_q, mode_d, ie_q, ie_d, lock_q, lock_d;
  logic              full_q, full_d, wrapped_q, wrapped_d, ovf_q, ovf_d;
  logic [7:0]        drops_q, drops_d;
  logic              clr;
  logic              mem_we;
  logic [LOG_AW-1:0] mem_idx;
  logic              full_o;

  logic [15:0]       chal_q [CHAL_WORDS];
  logic [31:0]       mem    [LOG_DEPTH];

  function automatic logic [15:0] lane_merge(input logic [15:0] old,
                                             input logic [15:0] d,
                                             input logic [1:0]  we);
    return {we[1] ? d[15:8] : old[15:8], we[0] ? d[7:0] : old[7:0]};
  endfunction

  // Range checks on the full-width word address so nothing outside the window aliases in.
  assign addr_w   = {18'd0, per_addr};
  assign sel_chal = (addr_w >= BASE_W) && (addr_w < META_W);
  assign sel_meta = (addr_w >= META_W) && (addr_w < LOG_W);
  assign sel_log  = (addr_w >= LOG_W)  && (addr_w < END_W);
  assign chal_idx = CAW'(addr_w - BASE_W);
  assign meta_idx = 3'(addr_w - META_W);
  assign log_off  = PW'(addr_w - LOG_W);
  assign wr_en    = per_en & (|per_we);
  assign rd_en    = per_en & ~(|per_we);

  always_comb begin
    ermin_d   = ermin_q;
    ermax_d   = ermax_q;
    ptr_d     = ptr_q;
    mode_d    = mode_q;
    ie_d      = ie_q;
    lock_d    = lock_q;
    full_d    = full_q;
    wrapped_d = wrapped_q;
    ovf_d     = ovf_q;
    drops_d   = drops_q;
    clr       = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = '0;
    base_ptr  = ptr_q;

    if (wr_en && sel_meta) begin
      case (meta_idx)
        3'd0: if (!lock_q) ermin_d = lane_merge(ermin_q, per_din, per_we);
        3'd1: if (!lock_q) ermax_d = lane_merge(ermax_q, per_din, per_we);
        3'd3: if (per_we[0]) begin
          mode_d = per_din[0];
          ie_d   = per_din[1];
          clr    = per_din[2];
          lock_d = lock_q | per_din[3];
        end
        default: ;
      endcase
    end

    // A clear lands before any same-cycle append, so the append sees an empty log.
    if (clr) begin
      ptr_d     = '0;
      full_d    = 1'b0;
      wrapped_d = 1'b0;
      ovf_d     = 1'b0;
      drops_d   = '0;
      base_ptr  = '0;
    end

    if (cflow_hw_wen) begin
      if (base_ptr < DEPTH_P) begin
        mem_we  = 1'b1;
        mem_idx = base_ptr[LOG_AW-1:0];
        if (mode_q && (base_ptr == DEPTH_P - 1'b1)) begin
          ptr_d     = '0;
          wrapped_d = 1'b1;
          full_d    = 1'b1;
        end else begin
          ptr_d = base_ptr + 1'b1;
          if (ptr_d == DEPTH_P) full_d = 1'b1;
        end
      end else if (mode_q) begin
        mem_we    = 1'b1;
        mem_idx   = '0;
        ptr_d     = PW'(1);
        wrapped_d = 1'b1;
        full_d    = 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
      end
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ermin_q   <= '0;
      ermax_q   <= '0;
      ptr_q     <= '0;
      mode_q    <= 1'b0;
      ie_q      <= 1'b0;
      lock_q    <= 1'b0;
      full_q    <= 1'b0;
      wrapped_q <= 1'b0;
      ovf_q     <= 1'b0;
      drops_q   <= '0;
      for (int unsigned i = 0; i < CHAL_WORDS; i++) chal_q[i] <= '0;
    end else begin
      ermin_q   <= ermin_d;
      ermax_q   <= ermax_d;
      ptr_q     <= ptr_d;
      mode_q    <= mode_d;
      ie_q      <= ie_d;
      lock_q    <= lock_d;
      full_q    <= full_d;
      wrapped_q <= wrapped_d;
      ovf_q     <= ovf_d;
      drops_q   <= drops_d;
      if (wr_en && sel_chal) chal_q[chal_idx] <= lane_merge(chal_q[chal_idx], per_din, per_we);
    end
  end

  always_ff @(posedge mclk) begin
    if (mem_we) mem[mem_idx] <= {cflow_src, cflow_dest};
  end

  // Halt mode reports fullness from the pointer; wrap mode keeps it sticky until clear.
  assign full_o   = mode_q ? full_q : (ptr_q == DEPTH_P);
  assign log_full = full_o;
  assign irq_log  = full_o & ie_q;
  assign ER_min   = ermin_q;
  assign ER_max   = ermax_q;
  assign log_ptr  = ptr_q;

  always_comb begin
    per_dout = '0;
    if (puc_rst_n && rd_en) begin
      if (sel_chal) begin
        per_dout = chal_q[chal_idx];
      end else if (sel_meta) begin
        case (meta_idx)
          3'd0:    per_dout = ermin_q;
          3'd1:    per_dout = ermax_q;
          3'd2:    per_dout = 16'(ptr_q);
          3'd3:    per_dout = {12'd0, lock_q, 1'b0, ie_q, mode_q};
          3'd4:    per_dout = {drops_q, 5'd0, ovf_q, wrapped_q, full_o};
          3'd5:    per_dout = 16'(LOG_DEPTH);
          default: per_dout = '0;
        endcase
      end else if (sel_log) begin
        per_dout = log_off[0] ? mem[log_off[PW-1:1]][15:0] : mem[log_off[PW-1:1]][31:16];
      end
    end
  end

endmodule

// File: tb/tb_acfa_log_ctrl.sv
// Self-checking bench for acfa_log_ctrl: vector tables, directed corner cases and
// randomized traffic against a procedural model of the log rules.
module tb_acfa_log_ctrl;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] cflow_src, cflow_dest;
  logic        cflow_hw_wen;
  logic [15:0] per_dout, ER_min, ER_max;
  logic [AW:0] log_ptr;
  logic        log_full, irq_log;

  always #5 mclk = ~mclk;

  acfa_log_ctrl #(.BASE_ADDR(15'h0180), .CHAL_WORDS(16), .LOG_AW(AW)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .cflow_src(cflow_src), .cflow_dest(cflow_dest),
    .cflow_hw_wen(cflow_hw_wen), .per_dout(per_dout), .ER_min(ER_min), .ER_max(ER_max),
    .log_ptr(log_ptr), .log_full(log_full), .irq_log(irq_log)
  );

  typedef struct { logic [15:0] addr; logic [15:0] exp; } vec_t;
  vec_t reset_tbl[$];
  vec_t app_tbl[$];

  int unsigned n_pass = 0, n_total = 0;

  // Reference model state
  logic [31:0] m_log [DEPTH];
  bit          m_valid [DEPTH];
  int          m_ptr, m_drops;
  bit          m_mode, m_ie, m_lock, m_seen_full, m_wrapped, m_ovf;
  logic [15:0] m_ermin, m_ermax;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] we);
    return {we[1] ? d[15:8] : o[15:8], we[0] ? d[7:0] : o[7:0]};
  endfunction

  function automatic void m_clear();
    m_ptr = 0; m_seen_full = 0; m_wrapped = 0; m_ovf = 0; m_drops = 0;
  endfunction

  function automatic void m_reset();
    m_clear();
    m_mode = 0; m_ie = 0; m_lock = 0; m_ermin = '0; m_ermax = '0;
  endfunction

  function automatic bit m_full();
    return m_mode ? m_seen_full : (m_ptr == DEPTH);
  endfunction

  function automatic logic [15:0] m_stat();
    logic [7:0] dr;
    dr = 8'(m_drops);
    return {dr, 5'd0, m_ovf, m_wrapped, m_full()};
  endfunction

  function automatic void m_append(input logic [15:0] s, input logic [15:0] d);
    if (m_ptr < DEPTH) begin
      m_log[m_ptr] = {s, d}; m_valid[m_ptr] = 1; m_ptr++;
      if (m_ptr == DEPTH) begin
        m_seen_full = 1;
        if (m_mode) begin m_ptr = 0; m_wrapped = 1; end
      end
    end else if (m_mode) begin
      m_log[0] = {s, d}; m_valid[0] = 1; m_ptr = 1; m_wrapped = 1; m_seen_full = 1;
    end else begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
  endfunction

  function automatic void m_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we);
    if (a == 16'h1A0 && !m_lock) m_ermin = merge(m_ermin, d, we);
    if (a == 16'h1A2 && !m_lock) m_ermax = merge(m_ermax, d, we);
    if (a == 16'h1A6 && we[0]) begin
      m_mode = d[0]; m_ie = d[1];
      if (d[3]) m_lock = 1;
      if (d[2]) m_clear();
    end
  endfunction

  // Drives one clock's worth of bus write and/or append, then mirrors it in the model.
  task automatic cyc(input bit do_wr, input logic [15:0] a, input logic [15:0] d, input logic [1:0] we,
                     input bit do_app, input logic [15:0] s, input logic [15:0] dst);
    if (do_wr) begin per_en = 1; per_we = we; per_addr = a[14:1]; per_din = d; end
    if (do_app) begin cflow_src = s; cflow_dest = dst; cflow_hw_wen = 1; end
    @(posedge mclk); #1;
    per_en = 0; per_we = 0; cflow_hw_wen = 0;
    if (do_wr) m_write(a, d, we);
    if (do_app) m_append(s, dst);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we);
    cyc(1, a, d, we, 0, '0, '0);
  endtask

  task automatic app(input logic [15:0] s, input logic [15:0] d);
    cyc(0, '0, '0, 2'b00, 1, s, d);
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [15:0] exp);
    per_en = 1; per_we = 0; per_addr = a[14:1];
    #1;
    check(nm, per_dout, exp);
    per_en = 0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".log_ptr"}, log_ptr, m_ptr);
    check({tag, ".log_full"}, log_full, m_full());
    check({tag, ".irq_log"}, irq_log, m_full() & m_ie);
    check({tag, ".ER_min"}, ER_min, m_ermin);
    check({tag, ".ER_max"}, ER_max, m_ermax);
  endtask

  initial begin
    reset_tbl.push_back('{16'h1A0, 16'h0000});
    reset_tbl.push_back('{16'h1A2, 16'h0000});
    reset_tbl.push_back('{16'h1A4, 16'h0000});
    reset_tbl.push_back('{16'h1A6, 16'h0000});
    reset_tbl.push_back('{16'h1A8, 16'h0000});
    reset_tbl.push_back('{16'h1AA, 16'h0040});
    reset_tbl.push_back('{16'h1AC, 16'h0000});
    reset_tbl.push_back('{16'h1AE, 16'h0000});
    reset_tbl.push_back('{16'h180, 16'h0000});
    reset_tbl.push_back('{16'h19E, 16'h0000});
    reset_tbl.push_back('{16'h17E, 16'h0000});
    reset_tbl.push_back('{16'h2B0, 16'h0000});
    app_tbl.push_back('{16'h1A4, 16'h0003});
    app_tbl.push_back('{16'h1B0, 16'h1000});
    app_tbl.push_back('{16'h1B2, 16'h2000});
    app_tbl.push_back('{16'h1B4, 16'h1004});
    app_tbl.push_back('{16'h1B6, 16'h3000});
    app_tbl.push_back('{16'h1B8, 16'h1008});
    app_tbl.push_back('{16'h1BA, 16'h4000});
    app_tbl.push_back('{16'h1A8, 16'h0000});

    puc_rst_n = 0; per_addr = '0; per_din = '0; per_en = 0; per_we = '0;
    cflow_src = '0; cflow_dest = '0; cflow_hw_wen = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    m_reset();
    repeat (2) @(posedge mclk);
    #1;
    check_outs("in_reset");
    puc_rst_n = 1;
    check_outs("reset");
    foreach (reset_tbl[i]) rd($sformatf("rst_rd_%h", reset_tbl[i].addr), reset_tbl[i].addr, reset_tbl[i].exp);

    // Register access and byte lanes
    wr(16'h1A0, 16'hAA11, 2'b11);
    rd("ermin_rb", 16'h1A0, 16'hAA11);
    check("ER_min_out", ER_min, 16'hAA11);
    wr(16'h1A2, 16'h1234, 2'b01);
    wr(16'h1A2, 16'hAB99, 2'b10);
    rd("ermax_lanes", 16'h1A2, 16'hAB34);
    wr(16'h19E, 16'hBEEF, 2'b11);
    rd("chal_rb", 16'h19E, 16'hBEEF);
    wr(16'h1AA, 16'hFFFF, 2'b11);
    rd("size_ro", 16'h1AA, 16'h0040);
    wr(16'h1A4, 16'h0005, 2'b11);
    rd("ptr_ro", 16'h1A4, 16'h0000);
    per_en = 1; per_we = 2'b11; per_addr = 14'h00D6; per_din = 16'h1234;
    #1;
    check("dout_on_write", per_dout, 16'h0000);
    per_en = 0; per_we = 0;

    // Three appends
    app(16'h1000, 16'h2000);
    app(16'h1004, 16'h3000);
    app(16'h1008, 16'h4000);
    foreach (app_tbl[i]) rd($sformatf("app_rd_%h", app_tbl[i].addr), app_tbl[i].addr, app_tbl[i].exp);
    check_outs("app3");
    wr(16'h1B0, 16'hDEAD, 2'b11);
    rd("log_wr_ignored", 16'h1B0, 16'h1000);

    // Halt mode overflow
    wr(16'h1A6, 16'h0006, 2'b01);
    rd("clr_ptr", 16'h1A4, 16'h0000);
    rd("ctrl_clr_reads0", 16'h1A6, 16'h0002);
    for (int i = 0; i < 66; i++) app(16'(16'h0100 + i), 16'(16'h8000 + i));
    rd("halt_ptr", 16'h1A4, 16'h0040);
    rd("halt_stat", 16'h1A8, 16'h0205);
    check("halt_irq", irq_log, 1'b1);
    rd("halt_e63_src", 16'h2AC, 16'h013F);
    rd("halt_e63_dst", 16'h2AE, 16'h803F);
    check_outs("halt");

    // Halt -> wrap while full
    wr(16'h1A6, 16'h0003, 2'b01);
    check("h2w_full", log_full, 1'b1);
    app(16'hAAAA, 16'hBBBB);
    rd("h2w_ptr", 16'h1A4, 16'h0001);
    rd("h2w_stat", 16'h1A8, m_stat());
    rd("h2w_e0", 16'h1B0, 16'hAAAA);

    // Wrap mode
    wr(16'h1A6, 16'h0005, 2'b01);
    for (int i = 0; i < 65; i++) app(16'(16'h2000 + i), 16'(16'h3000 + i));
    rd("wrap_ptr", 16'h1A4, 16'h0001);
    rd("wrap_stat", 16'h1A8, 16'h0003);
    rd("wrap_e0", 16'h1B0, 16'h2040);
    rd("wrap_e1", 16'h1B4, 16'h2001);
    check_outs("wrap");

    // Lock
    wr(16'h1A6, 16'h0009, 2'b01);
    wr(16'h1A0, 16'h5555, 2'b11);
    wr(16'h1A2, 16'h0000, 2'b11);
    wr(16'h1A6, 16'h0000, 2'b11);
    check("lock_ermin", ER_min, 16'hAA11);
    check("lock_ermax", ER_max, 16'hAB34);
    rd("lock_ctrl", 16'h1A6, 16'h0008);

    // Clear together with append
    cyc(1, 16'h1A6, 16'h0004, 2'b01, 1, 16'h7777, 16'h8888);
    rd("clrapp_ptr", 16'h1A4, 16'h0001);
    rd("clrapp_stat", 16'h1A8, 16'h0000);
    rd("clrapp_e0", 16'h1B0, 16'h7777);
    check_outs("clrapp");

    // Asynchronous reset in the middle of an append burst
    wr(16'h1A6, 16'h0002, 2'b01);
    for (int i = 0; i < 63; i++) app(16'(16'h4000 + i), 16'(16'h5000 + i));
    check_outs("pre_rst");
    cflow_src = 16'h9999; cflow_dest = 16'h9999; cflow_hw_wen = 1;
    per_en = 1; per_we = 0; per_addr = 14'h00D5;
    #3;
    puc_rst_n = 0;
    #1;
    check("arst_dout", per_dout, 16'h0000);
    check("arst_ermin", ER_min, 16'h0000);
    check("arst_ermax", ER_max, 16'h0000);
    check("arst_ptr", log_ptr, 7'd0);
    check("arst_full", log_full, 1'b0);
    check("arst_irq", irq_log, 1'b0);
    @(posedge mclk); #1;
    cflow_hw_wen = 0; per_en = 0;
    puc_rst_n = 1;
    m_reset();
    check_outs("post_rst");
    rd("post_rst_ctrl", 16'h1A6, 16'h0000);
    rd("post_rst_chal", 16'h19E, 16'h0000);
    app(16'hC0DE, 16'hF00D);
    rd("post_rst_ptr", 16'h1A4, 16'h0001);
    rd("post_rst_e0s", 16'h1B0, 16'hC0DE);
    rd("post_rst_e0d", 16'h1B2, 16'hF00D);

    // Randomized traffic
    for (int it = 0; it < 500; it++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        app(16'($urandom), 16'($urandom));
      end else if (r < 61) begin
        cyc(1, 16'h1A6, {13'd0, 1'b1, m_ie, m_mode}, 2'b01, 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom));
      end else if (r < 67) begin
        wr(16'h1A6, {14'd0, m_ie, ~m_mode}, 2'b01);
      end else if (r < 71) begin
        wr(16'h1A6, {14'd0, ~m_ie, m_mode}, 2'b01);
      end else if (r < 78) begin
        logic [1:0] we;
        we = 2'($urandom_range(1, 3));
        wr($urandom_range(0, 1) ? 16'h1A0 : 16'h1A2, 16'($urandom), we);
      end else begin
        int unsigned w;
        w = $urandom_range(0, 2 * DEPTH - 1);
        if (m_valid[w >> 1])
          rd("rnd_log", 16'(16'h1B0 + 2 * w), (w & 1) ? m_log[w >> 1][15:0] : m_log[w >> 1][31:16]);
        else
          rd("rnd_stat_alt", 16'h1A8, m_stat());
      end
      check_outs("rnd");
      rd("rnd_stat", 16'h1A8, m_stat());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/acfa_log_ctrl.md
Name: acfa_log_ctrl

Overview:
- Parametrised successor to the CFA metadata/log peripheral: one openMSP430 peripheral window holding the challenge, the ER bounds, a control/status block and the control-flow log.
- Log write pointer is owned internally; software no longer supplies it. Adds halt/wrap modes, full/overflow tracking, a saturating drop counter, a full interrupt, a software clear and a set-only ER lock.
- Sits on the per_* bus beside the CFA monitor, which drives cflow_src/cflow_dest/cflow_hw_wen.

Parameters:
- BASE_ADDR, 15'h0180, byte base of the window; must be 16-byte aligned.
- CHAL_WORDS, 16, number of 16-bit challenge words; must be a power of two.
- LOG_AW, 6, log2 of the log depth; LOG_DEPTH = 2^LOG_AW entries, each entry {src,dest} is 32 bits.
- Derived byte map (defaults in brackets):
  - Challenge: BASE_ADDR to +2*CHAL_WORDS-1 [0x180-0x19F].
  - Metadata: META = BASE_ADDR+2*CHAL_WORDS [0x1A0].
  - Log: LOG = META+0x10, 4*LOG_DEPTH bytes [0x1B0-0x2AF].

Ports:
- mclk  in  1  system clock
- puc_rst_n  in  1  asynchronous active-low reset
- per_addr  in  14  word address
- per_din  in  16  write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables
- cflow_src  in  16  branch source
- cflow_dest  in  16  branch destination
- cflow_hw_wen  in  1  one-cycle log append strobe, hardware only
- per_dout  out  16  read data; 0 when not selected or when writing
- ER_min  out  16  ERMIN register
- ER_max  out  16  ERMAX register
- log_ptr  out  LOG_AW+1  entries written (0..LOG_DEPTH)
- log_full  out  1  STAT.FULL
- irq_log  out  1  level IRQ = STAT.FULL & CTRL.IE

Behaviour:
- Reset (puc_rst_n=0, asynchronous) clears ERMIN, ERMAX, ptr, CTRL, STAT, drop count and all challenge words to 0. All outputs are 0 during reset. Log array contents are not reset.
- Bus reads are combinational, zero latency: per_dout is valid in the same cycle as per_en with per_we=0. Reads outside the window return 0.
- Bus writes take effect at the mclk edge. Each byte lane obeys its per_we bit independently.
- Metadata offsets:
  - +0 ERMIN, RW.
  - +2 ERMAX, RW.
  - +4 LOGPTR, RO, zero-extended ptr.
  - +6 CTRL, RW. [0] MODE (0=halt, 1=wrap); [1] IE; [2] CLR; [3] LOCK.
  - +8 STAT, RO. [0] FULL; [1] WRAPPED; [2] OVF; [15:8] DROPS.
  - +A SIZE, RO, reads LOG_DEPTH.
  - +C, +E: read 0, writes ignored.
- CLR is write-1 self-clearing and always reads 0. It sets ptr=0 and clears STAT. It does not clear log contents.
- LOCK is set-only. While LOCK=1, writes to ERMIN, ERMAX and CTRL[3] are ignored; MODE, IE and CLR stay writable. LOCK clears only on reset.
- Log region: word w maps to entry w>>1. w[0]=0 reads src, w[0]=1 reads dest. Bus writes to the log region are ignored.
- Append on cflow_hw_wen=1 at the mclk edge:
  - If ptr<LOG_DEPTH: mem[ptr]<={src,dest}; ptr<=ptr+1.
  - Halt mode, ptr==LOG_DEPTH: no write; OVF<=1; DROPS<=DROPS+1, saturating at 0xFF.
  - Wrap mode, at index LOG_DEPTH-1: write the entry, ptr<=0, WRAPPED<=1, FULL<=1.
- FULL:
  - Halt mode: FULL=1 whenever ptr==LOG_DEPTH.
  - Wrap mode: FULL is sticky until CLR.
- Changing MODE from halt to wrap while ptr==LOG_DEPTH: the next append writes entry 0, ptr<=1, WRAPPED<=1.
- Simultaneous CLR and append: CLR is applied first; the entry lands at index 0, ptr<=1, STAT otherwise cleared.
- ptr never exceeds LOG_DEPTH. No arithmetic on addresses is allowed to alias the challenge or metadata space.

Test Plan:
- Reset then read 0x1A0-0x1AA: returns 0,0,0,0,0,0x0040. Write 0x1A0=0xAA11 and read it back; ER_min=0xAA11.
- 3 appends (0x1000->0x2000, 0x1004->0x3000, 0x1008->0x4000): LOGPTR=3; 0x1B0=0x1000, 0x1B2=0x2000, 0x1B8=0x1008, 0x1BA=0x4000.
- Halt mode, 66 appends: LOGPTR=64, FULL=1, OVF=1, DROPS=2. With IE=1, irq_log=1. Entry 63 is intact.
- Wrap mode, 65 appends: LOGPTR=1, WRAPPED=1, FULL=1. 0x1B0 holds the 65th src.
- Set LOCK, then write ERMIN=0x5555 and CTRL=0: ER_min unchanged, LOCK still 1. CLR together with an append: LOGPTR=1, STAT=0.
- Assert puc_rst_n=0 mid-append burst: all outputs are 0 immediately, without waiting for a clock edge. After release, LOGPTR=0 and appends restart at entry 0.
